// File: rtl/cache_def.sv
// Shared cache/memory interface types plus the memory responder's state encoding.
package cache_def;

  parameter int MEM_LINE_OFFSET_BITS = 4;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_resp_state_type;

endpackage

// File: rtl/cache_mem_array.sv
// Single-port DEPTH_LINES x 128 line store: synchronous write, read registered on the same edge.
module cache_mem_array
  import cache_def::*;
#(
  parameter int DEPTH_LINES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_LINES)-1:0] idx,
  input  cache_data_type                 wdata,
  output cache_data_type                 rdata
);

  // Storage is deliberately not reset; it starts as zeros in simulation.
  cache_data_type store [DEPTH_LINES] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en && we) store[idx] <= wdata;
  end

  // A write echoes its own data so the response carries what was committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= we ? wdata : store[idx];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: fixed-latency 128-bit line read/write against cache_mem_array.
// Optional sticky requester-protocol check enabled by CACHE_MEM_PROTOCOL_CHECK_EN.
//
// state    | meaning
// MEM_IDLE | waiting for mem_req.valid; captures the request on acceptance
// MEM_WAIT | counting down the latency; live request inputs ignored
// MEM_RESP | ready high for one cycle with the line data
module cache_mem_responder
  import cache_def::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         proto_err
);

  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int IDX_LO   = MEM_LINE_OFFSET_BITS;
  localparam int IDX_HI   = MEM_LINE_OFFSET_BITS + IDX_BITS - 1;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("cache_mem_responder: LATENCY must be in 1..255");
  end
  if (DEPTH_LINES < 2 || (DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
    $error("cache_mem_responder: DEPTH_LINES must be a power of two >= 2");
  end

  mem_resp_state_type state;
  logic [7:0]         cnt;
  logic               ready;
  logic [31:0]        cap_addr;
  cache_data_type     cap_data;
  logic               cap_rw;

  logic                accept;
  logic                arr_en;
  logic                arr_we;
  logic [IDX_BITS-1:0] arr_idx;
  cache_data_type      arr_wdata;
  cache_data_type      arr_rdata;

  assign accept = (state == MEM_IDLE) && mem_req.valid;

  // The store is touched only on the edge entering RESP; with LATENCY==1 that
  // is the acceptance edge itself, so the live request drives the array there.
  assign arr_en    = ((state == MEM_WAIT) && (cnt == 8'd1)) || ((LATENCY == 1) && accept);
  assign arr_we    = (state == MEM_IDLE) ? mem_req.rw : cap_rw;
  assign arr_idx   = (state == MEM_IDLE) ? mem_req.addr[IDX_HI:IDX_LO] : cap_addr[IDX_HI:IDX_LO];
  assign arr_wdata = (state == MEM_IDLE) ? mem_req.data : cap_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_rw   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (mem_req.valid) begin
            cap_addr <= mem_req.addr;
            cap_data <= mem_req.data;
            cap_rw   <= mem_req.rw;
            cnt      <= CNT_LOAD;
            if (LATENCY == 1) begin
              state <= MEM_RESP;
              ready <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= MEM_RESP;
            ready <= 1'b1;
          end
        end
        MEM_RESP: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  cache_mem_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign mem_data.data  = arr_rdata;
  assign mem_data.ready = ready;

`ifdef CACHE_MEM_PROTOCOL_CHECK_EN
  logic err_q;
  logic violation;

  assign violation = ((state == MEM_WAIT) || (state == MEM_RESP)) &&
                     (!mem_req.valid || (mem_req.addr != cap_addr) ||
                      (mem_req.rw != cap_rw) || (mem_req.data != cap_data));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
      if (!err_q) $error("cache_mem_responder: request changed or dropped before ready");
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

  // Offset bits and aliased upper address bits never select a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr[IDX_LO-1:0], mem_req.addr[31:IDX_HI+1],
                              cap_addr[IDX_LO-1:0], cap_addr[31:IDX_HI+1]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder with LATENCY=4 and LATENCY=1 instances.
module tb_cache_mem_responder;
  import cache_def::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_req_type  req4, req1;
  mem_data_type rsp4, rsp1;
  logic         perr4, perr1;

  cache_mem_responder #(.LATENCY(4), .DEPTH_LINES(1024)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_req(req4), .mem_data(rsp4), .proto_err(perr4));
  cache_mem_responder #(.LATENCY(1), .DEPTH_LINES(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_data(rsp1), .proto_err(perr1));

`ifdef CACHE_MEM_PROTOCOL_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  localparam cache_data_type DATA_A = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam cache_data_type DATA_B = 128'h11112222_33334444_55556666_77778888;
  localparam cache_data_type DATA_C = 128'hCAFEF00D_00000001_00000002_0BADC0DE;
  localparam cache_data_type DATA_X = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  cache_data_type q4[$], q1[$];
  int rdy1_cyc[$];
  logic prev4 = 1'b0, prev1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ready pops one expected line and must be a single-cycle pulse.
  always @(negedge clk) begin
    cache_data_type e;
    if (rst_n && rsp4.ready) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL sb4_unexpected_ready got data=%h, expected no response", rsp4.data);
      end else begin
        e = q4.pop_front();
        if (rsp4.data !== e) begin
          fails++;
          $display("FAIL sb4_data got %h expected %h", rsp4.data, e);
        end
      end
      tests++;
      if (prev4 !== 1'b0) begin
        fails++;
        $display("FAIL sb4_ready_pulse ready high 2 cycles, expected 1");
      end
    end
    if (rst_n && rsp1.ready) begin
      rdy1_cyc.push_back(cyc);
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected_ready got data=%h, expected no response", rsp1.data);
      end else begin
        e = q1.pop_front();
        if (rsp1.data !== e) begin
          fails++;
          $display("FAIL sb1_data got %h expected %h", rsp1.data, e);
        end
      end
      tests++;
      if (prev1 !== 1'b0) begin
        fails++;
        $display("FAIL sb1_ready_pulse ready high 2 cycles, expected 1");
      end
    end
    prev4 = rsp4.ready;
    prev1 = rsp1.ready;
  end

  // Issues one request (caller is just after an edge), waits for ready, returns
  // #1 after the edge that ends the ready cycle with valid still asserted.
  task automatic do_req(input bit sel, input logic [31:0] a, input cache_data_type d,
                        input logic rw, input cache_data_type exp, output int lat);
    int n = 0;
    bit ok = 0;
    if (sel) begin req1 = '{addr: a, data: d, rw: rw, valid: 1'b1}; q1.push_back(exp); end
    else     begin req4 = '{addr: a, data: d, rw: rw, valid: 1'b1}; q4.push_back(exp); end
    @(posedge clk);
    repeat (20) begin
      @(negedge clk);
      if ((sel ? rsp1.ready : rsp4.ready) === 1'b1) begin ok = 1; break; end
      n++;
    end
    lat = n + 1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL req_timeout addr=%h no ready within 20 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req4 = '0;
    req1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests += 6;
    if (rsp4.ready !== 1'b0) begin fails++; $display("FAIL rst_ready4 got %b expected 0", rsp4.ready); end
    if (rsp4.data !== '0)    begin fails++; $display("FAIL rst_data4 got %h expected 0", rsp4.data); end
    if (perr4 !== 1'b0)      begin fails++; $display("FAIL rst_perr4 got %b expected 0", perr4); end
    if (rsp1.ready !== 1'b0) begin fails++; $display("FAIL rst_ready1 got %b expected 0", rsp1.ready); end
    if (rsp1.data !== '0)    begin fails++; $display("FAIL rst_data1 got %h expected 0", rsp1.data); end
    if (perr1 !== 1'b0)      begin fails++; $display("FAIL rst_perr1 got %b expected 0", perr1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_at_reset();
    int lat;
    do_req(1'b0, 32'h0000_0040, '0, 1'b0, '0, lat);
    req4.valid = 1'b0;
    tests++;
    if (lat != 4) begin fails++; $display("FAIL read0_latency got %0d expected 4", lat); end
  endtask

  task automatic test_raw_back_to_back();
    int lat_w, lat_r;
    do_req(1'b0, 32'h0000_0010, DATA_A, 1'b1, DATA_A, lat_w);
    do_req(1'b0, 32'h0000_001C, '0, 1'b0, DATA_A, lat_r);
    req4.valid = 1'b0;
    tests += 2;
    if (lat_w != 4) begin fails++; $display("FAIL raw_wlat got %0d expected 4", lat_w); end
    if (lat_r != 4) begin fails++; $display("FAIL raw_rlat got %0d expected 4", lat_r); end
  endtask

  task automatic test_alias();
    int lat;
    do_req(1'b0, 32'h0000_4010, DATA_B, 1'b1, DATA_B, lat);
    req4.valid = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h0000_0010, '0, 1'b0, DATA_B, lat);
    req4.valid = 1'b0;
    tests++;
    if (lat != 4) begin fails++; $display("FAIL alias_latency got %0d expected 4", lat); end
  endtask

  task automatic test_latency1();
    int lat [3];
    rdy1_cyc.delete();
    do_req(1'b1, 32'h0000_0020, DATA_X, 1'b1, DATA_X, lat[0]);
    do_req(1'b1, 32'h0000_0024, '0, 1'b0, DATA_X, lat[1]);
    do_req(1'b1, 32'h0000_0030, '0, 1'b0, '0, lat[2]);
    req1.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (lat[i] != 1) begin fails++; $display("FAIL lat1_latency req%0d got %0d expected 1", i, lat[i]); end
    end
    tests++;
    if (rdy1_cyc.size() != 3) begin
      fails++;
      $display("FAIL lat1_count got %0d responses expected 3", rdy1_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (rdy1_cyc[i] - rdy1_cyc[i-1] != 2) begin
          fails++;
          $display("FAIL lat1_throughput gap%0d got %0d expected 2", i, rdy1_cyc[i] - rdy1_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_idle_hold();
    req4.valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests += 2;
    if (rsp4.ready !== 1'b0) begin fails++; $display("FAIL idle_ready got %b expected 0", rsp4.ready); end
    if (rsp4.data !== DATA_B) begin fails++; $display("FAIL idle_hold_data got %h expected %h", rsp4.data, DATA_B); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    int lat;
    req4 = '{addr: 32'h0000_0010, data: DATA_C, rw: 1'b1, valid: 1'b1};
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req4.valid = 1'b0;
    #1;
    tests += 2;
    if (rsp4.ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b expected 0", rsp4.ready); end
    if (rsp4.data !== '0)    begin fails++; $display("FAIL midrst_data got %h expected 0", rsp4.data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    do_req(1'b0, 32'h0000_0010, '0, 1'b0, DATA_B, lat);
    req4.valid = 1'b0;
  endtask

  task automatic test_protocol();
    bit ok = 0;
    req4 = '{addr: 32'h0000_0010, data: '0, rw: 1'b0, valid: 1'b1};
    q4.push_back(DATA_B);
    @(posedge clk); #1;
    req4.addr = 32'h0000_0040;
    repeat (20) begin
      @(negedge clk);
      if (rsp4.ready === 1'b1) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL proto_timeout no ready within 20 cycles"); end
    @(posedge clk); #1;
    req4.valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests += 2;
    if (perr4 !== EXP_PERR) begin fails++; $display("FAIL proto_err_held got %b expected %b", perr4, EXP_PERR); end
    if (perr1 !== 1'b0)     begin fails++; $display("FAIL proto_err_clean got %b expected 0", perr1); end
    rst_n = 1'b0;
    #2;
    tests++;
    if (perr4 !== 1'b0) begin fails++; $display("FAIL proto_err_reset got %b expected 0", perr4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read_at_reset();
    test_raw_back_to_back();
    test_alias();
    test_latency1();
    test_idle_hold();
    test_reset_mid_write();
    test_protocol();
    repeat (3) @(posedge clk);
    tests += 2;
    if (q4.size() != 0) begin fails++; $display("FAIL sb4_leftover got %0d pending expected 0", q4.size()); end
    if (q1.size() != 0) begin fails++; $display("FAIL sb1_leftover got %0d pending expected 0", q1.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
